// File: rtl/register_file.sv
// 32-entry register file with two combinational read ports, write-back bypass,
// and a load scoreboard (busy bits) with clear-bypass for stall release.
module register_file #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            rs1_addr,
    input  logic [4:0]            rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  reg_write,
    input  logic [4:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  busy_set,
    input  logic [4:0]            busy_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [31:0]           busy_vector
);

    localparam int REG_COUNT = 32;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;

    logic wr_fire;
    logic set_fire;
    logic rs1_hit;
    logic rs2_hit;

    assign wr_fire  = rst_n & reg_write & (rd_addr != 5'd0);
    assign set_fire = rst_n & busy_set & (busy_addr != 5'd0);
    assign rs1_hit  = wr_fire & (rd_addr == rs1_addr);
    assign rs2_hit  = wr_fire & (rd_addr == rs2_addr);

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_fire) begin
            regs_d[rd_addr] = write_data;
            busy_d[rd_addr] = 1'b0;
        end
        // The set is applied after the clear: a load issued now supersedes the
        // write-back completing now, so the bit must remain set.
        if (set_fire) begin
            busy_d[busy_addr] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Same-cycle write-back forwards data and releases the stall.
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : (rs1_hit ? write_data : regs_q[rs1_addr]);
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : (rs2_hit ? write_data : regs_q[rs2_addr]);
    assign rs1_busy = busy_q[rs1_addr] & ~rs1_hit;
    assign rs2_busy = busy_q[rs2_addr] & ~rs2_hit;
    assign busy_vector = busy_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file: a behavioural model of registers and
// busy bits is compared every cycle, plus literal expectations for key scenarios.
module tb_register_file;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_addr, rs2_addr, rd_addr, busy_addr;
    logic [DW-1:0] rs1_data, rs2_data, write_data;
    logic          reg_write, busy_set, rs1_busy, rs2_busy;
    logic [31:0]   busy_vector;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_regs [32];
    bit   [31:0]   m_busy;

    register_file #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vector(busy_vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // What a read port must show given the current storage model and inputs.
    function automatic logic [DW-1:0] exp_data(input logic [4:0] a);
        if (a == 0) return '0;
        if (rst_n && reg_write && rd_addr == a) return write_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return m_busy[a] && !(rst_n && reg_write && rd_addr == a);
    endfunction

    // Reference state update at each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (reg_write && rd_addr != 0) begin
                m_regs[rd_addr] = write_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            check("rs1_data", rs1_data, exp_data(rs1_addr));
            check("rs2_data", rs2_data, exp_data(rs2_addr));
            check("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(rs1_addr)});
            check("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(rs2_addr)});
            check("busy_vector", busy_vector, m_busy);
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [DW-1:0] wd, input logic bs, input logic [4:0] ba,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst_n = rst; reg_write = we; rd_addr = rd; write_data = wd;
        busy_set = bs; busy_addr = ba; rs1_addr = r1; rs2_addr = r2;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b1, 1'b0, 5'd0, '0, 1'b0, 5'd0, r1, r2);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        rst_n = 1'b0; reg_write = 1'b0; rd_addr = '0; write_data = '0;
        busy_set = 1'b0; busy_addr = '0; rs1_addr = '0; rs2_addr = '0;
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 5'd0, 5'd0);
        #3;
        check("reset_busy_vector", busy_vector, 32'h0);

        // Basic write then read
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        #3;
        check("x5_read", rs1_data, 32'hDEADBEEF);
        check("x0_read", rs2_data, 32'h0);

        // Writes and busy sets to x0 are discarded
        drive(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        #3;
        check("x0_no_bypass", rs1_data, 32'h0);
        idle(5'd0, 5'd0);
        #3;
        check("x0_after_write", rs1_data, 32'h0);
        check("busy0_stays0", {31'b0, busy_vector[0]}, 32'h0);

        // Same-cycle bypass on both ports
        drive(1'b1, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7);
        #3;
        check("bypass_rs1", rs1_data, 32'hA5A5A5A5);
        check("bypass_rs2", rs2_data, 32'hA5A5A5A5);
        idle(5'd7, 5'd5);
        #3;
        check("x7_stored", rs1_data, 32'hA5A5A5A5);

        // Scoreboard set, then release on write-back
        drive(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        #3;
        check("set_not_visible", {31'b0, rs1_busy}, 32'h0);
        idle(5'd9, 5'd0);
        #3;
        check("x9_busy", {31'b0, rs1_busy}, 32'h1);
        check("bv9_set", busy_vector, 32'h0000_0200);
        drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd0);
        #3;
        check("x9_clear_bypass", {31'b0, rs1_busy}, 32'h0);
        idle(5'd9, 5'd0);
        #3;
        check("bv9_cleared", busy_vector, 32'h0);

        // Simultaneous set and clear of the same index: set wins
        drive(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd9, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 5'd9, 32'h38383838, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        #3;
        check("bv9_set_wins", busy_vector, 32'h0000_0200);
        check("x9_written", rs1_data, 32'h38383838);
        check("x9_busy_again", {31'b0, rs1_busy}, 32'h1);

        // Populate, mark busy, then reset
        for (int i = 1; i < 32; i++)
            drive(1'b1, 1'b1, 5'(i), 32'h01010101 * i + 1, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd3, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd4, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 5'd6, 32'hFFFF, 1'b1, 5'd5, 5'd6, 5'd3);
        #3;
        check("rst_no_bypass", rs1_data, 32'h06060607);
        check("rst_busy_storage", {31'b0, rs2_busy}, 32'h1);
        idle(5'd3, 5'd4);
        #3;
        check("post_rst_bv", busy_vector, 32'h0);
        check("post_rst_busy1", {31'b0, rs1_busy}, 32'h0);
        check("post_rst_busy2", {31'b0, rs2_busy}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            idle(5'(i), 5'(31 - i));
            #3;
            check("post_rst_rd1", rs1_data, 32'h0);
            check("post_rst_rd2", rs2_data, 32'h0);
        end
        drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd3, 5'd0);
        #3;
        check("wb_after_rst", rs1_data, 32'h33);

        // Randomized traffic; narrow address range often to force collisions
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] mask;
            mask = ($urandom_range(0, 1) == 0) ? 5'h07 : 5'h1F;
            drive(($urandom_range(0, 49) != 0), 1'($urandom), 5'($urandom) & mask, $urandom,
                  1'($urandom), 5'($urandom) & mask, 5'($urandom) & mask, 5'($urandom) & mask);
        end
        @(negedge clk);
        #3;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
